// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS-style control FSM with a memory-wait timeout.
// Define MC_CONTROLLER_BNE_EN to decode bne (000101) as a branch on not-equal.
module mc_controller #(
    parameter int ALU_CTL_W      = 3,
    parameter int FETCH_WAIT_MAX = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [5:0]           op_i6,
    input  logic [5:0]           funct_i6,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 pc_en_o,
    output logic                 iord_o,
    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic                 ir_write_o,
    output logic                 reg_dst_rtrd_o,
    output logic                 mem_to_reg_o,
    output logic                 enable_wreg_o,
    output logic                 alu_src_a_o,
    output logic [1:0]           alu_src_b_o2,
    output logic [1:0]           pc_src_o2,
    output logic [ALU_CTL_W-1:0] alu_control_o,
    output logic                 illegal_op_o,
    output logic                 mem_timeout_o,
    output logic [3:0]           state_o4
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
        EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
    } state_t;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_J = 6'b000010, OP_BNE = 6'b000101;
`ifdef MC_CONTROLLER_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif
    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [2:0] alu_ctl;
    logic       is_bne, waiting, timeout;

    assign is_bne        = BNE_EN && op_i6 == OP_BNE;
    assign alu_control_o = ALU_CTL_W'(alu_ctl);
    assign state_o4      = state_q;

    always_comb begin
        state_d        = state_q;
        pc_en_o        = 1'b0;
        iord_o         = 1'b0;
        mem_req_o      = 1'b0;
        mem_write_o    = 1'b0;
        ir_write_o     = 1'b0;
        reg_dst_rtrd_o = 1'b0;
        mem_to_reg_o   = 1'b0;
        enable_wreg_o  = 1'b0;
        alu_src_a_o    = 1'b0;
        alu_src_b_o2   = 2'b00;
        pc_src_o2      = 2'b00;
        alu_ctl        = 3'b000;
        illegal_op_o   = 1'b0;
        mem_timeout_o  = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req_o    = 1'b1;
                alu_src_b_o2 = 2'b01;
                alu_ctl      = 3'b010;
                // gated by reset so no PC/IR load can happen while held in reset
                ir_write_o   = mem_ready_i & rst_n_i;
                pc_en_o      = mem_ready_i & rst_n_i;
                state_d      = mem_ready_i ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b_o2 = 2'b11;
                alu_ctl      = 3'b010;
                case (op_i6)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    OP_BNE: begin
                        state_d      = BNE_EN ? BRANCH : FETCH;
                        illegal_op_o = !BNE_EN;
                    end
                    default: begin
                        state_d      = FETCH;
                        illegal_op_o = 1'b1;
                    end
                endcase
            end
            MEMADR, ADDIEX: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o2 = 2'b10;
                alu_ctl      = 3'b010;
                state_d      = state_q == ADDIEX ? ADDIWB : (op_i6 == OP_LW ? MEMRD : MEMWR);
            end
            MEMRD: begin
                iord_o    = 1'b1;
                mem_req_o = 1'b1;
                state_d   = mem_ready_i ? MEMWB : MEMRD;
            end
            MEMWR: begin
                iord_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                state_d     = mem_ready_i ? FETCH : MEMWR;
            end
            MEMWB: begin
                enable_wreg_o = 1'b1;
                mem_to_reg_o  = 1'b1;
                state_d       = FETCH;
            end
            EXEC: begin
                case (funct_i6)
                    6'b100000: alu_ctl = 3'b010;
                    6'b100010: alu_ctl = 3'b110;
                    6'b100100: alu_ctl = 3'b000;
                    6'b100101: alu_ctl = 3'b001;
                    6'b101010: alu_ctl = 3'b111;
                    default: begin
                        alu_ctl      = 3'b010;
                        illegal_op_o = 1'b1;
                    end
                endcase
                state_d = ALUWB;
            end
            ALUWB: begin
                enable_wreg_o  = 1'b1;
                reg_dst_rtrd_o = 1'b1;
                state_d        = FETCH;
            end
            ADDIWB: begin
                enable_wreg_o = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                alu_src_a_o = 1'b1;
                pc_src_o2   = 2'b01;
                alu_ctl     = 3'b110;
                pc_en_o     = is_bne ? !zero_i : zero_i;
                state_d     = FETCH;
            end
            JUMP: begin
                pc_src_o2 = 2'b10;
                pc_en_o   = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
        waiting = mem_req_o && !mem_ready_i;
        timeout = waiting && wait_q == 8'(FETCH_WAIT_MAX);
        // a timed-out write must not strobe memory on the abandoning cycle
        if (timeout) begin
            state_d       = FETCH;
            mem_write_o   = 1'b0;
            mem_timeout_o = 1'b1;
        end
        wait_d = (state_d != state_q || timeout) ? 8'd0 : wait_q + 8'(waiting);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FETCH;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: vector table, directed corner sequences and a randomized
// instruction-level reference model for mc_controller.
module tb_mc_controller;
`ifdef MC_CONTROLLER_BNE_EN
    localparam bit BNE = 1'b1;
`else
    localparam bit BNE = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n_i, zero_i, mem_ready_i;
    logic [5:0] op_i6, funct_i6;
    logic       pc_en_o, iord_o, mem_req_o, mem_write_o, ir_write_o;
    logic       reg_dst_rtrd_o, mem_to_reg_o, enable_wreg_o, alu_src_a_o;
    logic [1:0] alu_src_b_o2, pc_src_o2;
    logic [2:0] alu_control_o;
    logic       illegal_op_o, mem_timeout_o;
    logic [3:0] state_o4;
    int total = 0, bad = 0;

    mc_controller dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .op_i6(op_i6), .funct_i6(funct_i6),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i), .pc_en_o(pc_en_o), .iord_o(iord_o),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
        .reg_dst_rtrd_o(reg_dst_rtrd_o), .mem_to_reg_o(mem_to_reg_o),
        .enable_wreg_o(enable_wreg_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o2(alu_src_b_o2), .pc_src_o2(pc_src_o2), .alu_control_o(alu_control_o),
        .illegal_op_o(illegal_op_o), .mem_timeout_o(mem_timeout_o), .state_o4(state_o4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cyc, ill, pce, wr, mw;
        logic [2:0] alu2;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic z,
                                input int c, input int il, input int p, input int w,
                                input int m, input logic [2:0] a);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.cyc = c; v.ill = il;
        v.pce = p; v.wr = w; v.mw = m; v.alu2 = a;
        return v;
    endfunction

    function automatic bit op_legal(input logic [5:0] o);
        return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010}
               || (BNE && o == 6'b000101);
    endfunction

    function automatic bit funct_legal(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [2:0] exp_alu(input int s, input logic [5:0] f);
        if (s == 6)
            case (f)
                6'b100010: return 3'b110;
                6'b100100: return 3'b000;
                6'b100101: return 3'b001;
                6'b101010: return 3'b111;
                default:   return 3'b010;
            endcase
        if (s inside {0, 1, 2, 9}) return 3'b010;
        if (s == 8) return 3'b110;
        return 3'b000;
    endfunction

    // Runs one instruction from FETCH with memory always ready; entered/left at negedge+1 in FETCH.
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z,
                       output int cyc, output int ill, output int pce, output int wr,
                       output int mw, output logic [2:0] alu2);
        op_i6 = o; funct_i6 = f; zero_i = z; mem_ready_i = 1'b1;
        cyc = 0; ill = 0; pce = 0; wr = 0; mw = 0; alu2 = 3'b000;
        #1;
        for (int n = 0; n < 20; n++) begin
            if (n == 2) alu2 = alu_control_o;
            if (n > 0 && state_o4 == 4'd0) begin
                cyc = n;
                break;
            end
            ill += int'(illegal_op_o);
            pce += int'(pc_en_o);
            wr  += int'(enable_wreg_o);
            mw  += int'(mem_write_o);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input int s);
        for (int n = 0; n < 40 && int'(state_o4) != s; n++) begin
            @(negedge clk);
            #1;
        end
        if (int'(state_o4) != s) chk("wait_state", int'(state_o4), s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[$];
        int cyc, ill, pce, wr, mw, irw, inwr, tcnt, tk, mwc, ms, wcnt;
        logic [2:0] alu2;
        int q[$];
        logic [5:0] ops[8];
        logic [5:0] fns[6];
        bit eb;

        tv.push_back(mk(6'b100011, 6'b000000, 1'b0, 5, 0, 1, 1, 0, 3'b010));
        tv.push_back(mk(6'b101011, 6'b000000, 1'b0, 4, 0, 1, 0, 1, 3'b010));
        tv.push_back(mk(6'b000000, 6'b100000, 1'b0, 4, 0, 1, 1, 0, 3'b010));
        tv.push_back(mk(6'b000000, 6'b100010, 1'b0, 4, 0, 1, 1, 0, 3'b110));
        tv.push_back(mk(6'b000000, 6'b100100, 1'b0, 4, 0, 1, 1, 0, 3'b000));
        tv.push_back(mk(6'b000000, 6'b100101, 1'b0, 4, 0, 1, 1, 0, 3'b001));
        tv.push_back(mk(6'b000000, 6'b101010, 1'b0, 4, 0, 1, 1, 0, 3'b111));
        tv.push_back(mk(6'b000000, 6'b111111, 1'b0, 4, 1, 1, 1, 0, 3'b010));
        tv.push_back(mk(6'b000100, 6'b000000, 1'b1, 3, 0, 2, 0, 0, 3'b110));
        tv.push_back(mk(6'b000100, 6'b000000, 1'b0, 3, 0, 1, 0, 0, 3'b110));
        tv.push_back(mk(6'b001000, 6'b000000, 1'b0, 4, 0, 1, 1, 0, 3'b010));
        tv.push_back(mk(6'b000010, 6'b000000, 1'b0, 3, 0, 2, 0, 0, 3'b000));
        tv.push_back(mk(6'b111111, 6'b000000, 1'b0, 2, 1, 1, 0, 0, 3'b010));
        if (BNE) begin
            tv.push_back(mk(6'b000101, 6'b000000, 1'b0, 3, 0, 2, 0, 0, 3'b110));
            tv.push_back(mk(6'b000101, 6'b000000, 1'b1, 3, 0, 1, 0, 0, 3'b110));
        end else begin
            tv.push_back(mk(6'b000101, 6'b000000, 1'b0, 2, 1, 1, 0, 0, 3'b010));
            tv.push_back(mk(6'b000101, 6'b000000, 1'b1, 2, 1, 1, 0, 0, 3'b010));
        end

        rst_n_i = 1'b0; op_i6 = 6'd0; funct_i6 = 6'd0; zero_i = 1'b0; mem_ready_i = 1'b1;
        #1;
        chk("rst_state", int'(state_o4), 0);
        chk("rst_mem_req", int'(mem_req_o), 1);
        chk("rst_src_b", int'(alu_src_b_o2), 1);
        chk("rst_alu", int'(alu_control_o), 2);
        chk("rst_pc_en", int'(pc_en_o), 0);
        chk("rst_ir_write", int'(ir_write_o), 0);
        chk("rst_strobes", int'({iord_o, mem_write_o, enable_wreg_o, illegal_op_o, mem_timeout_o}), 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_state", int'(state_o4), 0);
        rst_n_i = 1'b1;

        foreach (tv[i]) begin
            run(tv[i].op, tv[i].funct, tv[i].zero, cyc, ill, pce, wr, mw, alu2);
            chk($sformatf("v%0d_cycles", i), cyc, tv[i].cyc);
            chk($sformatf("v%0d_illegal", i), ill, tv[i].ill);
            chk($sformatf("v%0d_pc_en", i), pce, tv[i].pce);
            chk($sformatf("v%0d_wreg", i), wr, tv[i].wr);
            chk($sformatf("v%0d_mem_write", i), mw, tv[i].mw);
            chk($sformatf("v%0d_alu", i), int'(alu2), int'(tv[i].alu2));
        end

        // FETCH waits three cycles, completes on the fourth
        op_i6 = 6'b000000; funct_i6 = 6'b100000; irw = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready_i = (i == 3);
            #1;
            chk($sformatf("fwait_state%0d", i), int'(state_o4), 0);
            irw += int'(ir_write_o);
            @(negedge clk);
            #1;
        end
        chk("fwait_decode", int'(state_o4), 1);
        chk("fwait_ir_pulses", irw, 1);
        mem_ready_i = 1'b1;
        wait_state(0);

        // sw stalled in MEMWR until the timeout fires
        op_i6 = 6'b101011;
        wait_state(2);
        mem_ready_i = 1'b0;
        inwr = 0; tcnt = 0; tk = 0; mwc = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            inwr += int'(state_o4 == 4'd5);
            tcnt += int'(mem_timeout_o);
            if (mem_timeout_o) tk = k;
            mwc += int'(mem_write_o);
        end
        @(negedge clk);
        #1;
        chk("to_next_fetch", int'(state_o4), 0);
        chk("to_cycles_in_memwr", inwr, 16);
        chk("to_pulses", tcnt, 1);
        chk("to_pulse_cycle", tk, 16);
        chk("to_write_cycles", mwc, 15);
        mem_ready_i = 1'b1;
        wait_state(0);

        // reset dropped while a store is stalled in MEMWR
        op_i6 = 6'b101011;
        wait_state(2);
        mem_ready_i = 1'b0;
        @(negedge clk);
        #1;
        chk("mr_in_memwr", int'(state_o4), 5);
        #1;
        rst_n_i = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        chk("mr_async_state", int'(state_o4), 0);
        chk("mr_pc_en", int'(pc_en_o), 0);
        chk("mr_ir_write", int'(ir_write_o), 0);
        chk("mr_mem_write", int'(mem_write_o), 0);
        @(negedge clk);
        rst_n_i = 1'b1;
        run(6'b100011, 6'b000000, 1'b0, cyc, ill, pce, wr, mw, alu2);
        chk("mr_lw_cycles", cyc, 5);
        chk("mr_lw_wreg", wr, 1);
        chk("mr_lw_mem_write", mw, 0);

        // randomized instruction stream against the path model
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b110011};
        ms = 0; wcnt = 0;
        for (int c = 0; c < 2000; c++) begin
            if (ms == 0) begin
                op_i6 = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
                funct_i6 = fns[$urandom_range(0, 5)];
            end
            zero_i = 1'($urandom);
            mem_ready_i = (wcnt >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            eb = BNE && op_i6 == 6'b000101;
            chk("rnd_state", int'(state_o4), ms);
            chk("rnd_ir_write", int'(ir_write_o), int'(ms == 0 && mem_ready_i));
            chk("rnd_pc_en", int'(pc_en_o),
                int'((ms == 0 && mem_ready_i) || ms == 11 || (ms == 8 && (eb ? !zero_i : zero_i))));
            chk("rnd_wreg", int'(enable_wreg_o), int'(ms inside {4, 7, 10}));
            chk("rnd_mem_write", int'(mem_write_o), int'(ms == 5));
            chk("rnd_mem_req", int'(mem_req_o), int'(ms inside {0, 3, 5}));
            chk("rnd_illegal", int'(illegal_op_o),
                int'((ms == 1 && !op_legal(op_i6)) || (ms == 6 && !funct_legal(funct_i6))));
            chk("rnd_alu", int'(alu_control_o), int'(exp_alu(ms, funct_i6)));
            chk("rnd_timeout", int'(mem_timeout_o), 0);
            if (ms inside {0, 3, 5} && !mem_ready_i) wcnt++;
            else begin
                wcnt = 0;
                if (ms == 0)
                    case (op_i6)
                        6'b100011: q = '{1, 2, 3, 4};
                        6'b101011: q = '{1, 2, 5};
                        6'b000000: q = '{1, 6, 7};
                        6'b000100: q = '{1, 8};
                        6'b001000: q = '{1, 9, 10};
                        6'b000010: q = '{1, 11};
                        6'b000101: q = BNE ? '{1, 8} : '{1};
                        default:   q = '{1};
                    endcase
                ms = (q.size() > 0) ? q.pop_front() : 0;
            end
            @(negedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
